// File: rtl/n64_button_arbiter.sv
// n64_button_arbiter
// Lets two button sources share the emulator's 16-bit button_state.
// Source A is the physical pad scanner. Source B is the replay/debug injector.
// Ownership is granted round-robin. Data and ownership changes are committed
// only in RX cycles (cur_operation=0), so a TX frame never carries torn data.
// Button words that arrive during TX are parked in a one-deep pending slot.
// An owner that stays silent for STALE_CYCLES cycles is released, and the
// buttons are forced to neutral.
//
// Ports:
//   sample_clk             system clock, rising edge
//   reset                  synchronous, active-high
//   cur_operation          0 = RX (commit window), 1 = TX (freeze)
//   req_a / req_b          level ownership requests
//   valid_a / valid_b      single-cycle data strobes
//   data_a / data_b        button words, sampled with the matching valid
//   button_state           registered button word sent to the emulator
//   grant_a / grant_b      registered, one-hot or zero
//   stale                  sticky: the last release was caused by timeout
module n64_button_arbiter #(
  parameter int STALE_CYCLES = 1000000
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        cur_operation,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        valid_a,
  input  logic        valid_b,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  output logic [15:0] button_state,
  output logic        grant_a,
  output logic        grant_b,
  output logic        stale
);

  localparam int TW = $clog2(STALE_CYCLES + 1);
  localparam logic [TW-1:0] STALE_MAX = TW'(STALE_CYCLES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam logic LG_A = 1'b0;
  localparam logic LG_B = 1'b1;

  logic [1:0]    state;
  logic          last_grant;
  logic [TW-1:0] timer;
  logic          pending;
  logic [15:0]   pending_data;

  logic        commit;
  logic        own_req;
  logic        own_valid;
  logic [15:0] own_data;
  logic        pick_a;

  assign commit = ~cur_operation;

  // Route the current owner's signals. Signals from the non-owner never reach
  // the datapath.
  always_comb begin
    own_req   = 1'b0;
    own_valid = 1'b0;
    own_data  = 16'h0000;
    if (state == OWN_A) begin
      own_req   = req_a;
      own_valid = valid_a;
      own_data  = data_a;
    end else if (state == OWN_B) begin
      own_req   = req_b;
      own_valid = valid_b;
      own_data  = data_b;
    end
  end

  // On a tie, the source that did not win last time gets the grant.
  assign pick_a = req_a & (~req_b | (last_grant == LG_B));

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= LG_B;
      timer        <= '0;
      pending      <= 1'b0;
      pending_data <= 16'h0000;
      button_state <= 16'h0000;
      grant_a      <= 1'b0;
      grant_b      <= 1'b0;
      stale        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          // A valid in the grant cycle is dropped. The new owner cannot see
          // the grant yet.
          if (commit && (req_a || req_b)) begin
            state      <= pick_a ? OWN_A : OWN_B;
            grant_a    <= pick_a;
            grant_b    <= ~pick_a;
            last_grant <= pick_a ? LG_A : LG_B;
            stale      <= 1'b0;
            pending    <= 1'b0;
          end
        end
        OWN_A, OWN_B: begin
          if (commit && (!own_req || timer == STALE_MAX)) begin
            // A dropped request is checked first, so the timeout flag is set
            // only when the owner still wants the pad.
            state        <= IDLE;
            grant_a      <= 1'b0;
            grant_b      <= 1'b0;
            button_state <= 16'h0000;
            timer        <= '0;
            if (own_req) stale <= 1'b1;
          end else if (own_valid) begin
            timer <= '0;
            if (commit) begin
              button_state <= own_data;
              pending      <= 1'b0;
            end else begin
              pending_data <= own_data;
              pending      <= 1'b1;
            end
          end else begin
            if (timer != STALE_MAX) timer <= timer + 1'b1;
            if (commit && pending) begin
              button_state <= pending_data;
              pending      <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_a <= 1'b0;
          grant_b <= 1'b0;
          timer   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_button_arbiter.sv
module tb_n64_button_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cur_op;
  logic        req_a, req_b, valid_a, valid_b;
  logic [15:0] data_a, data_b;
  logic [15:0] button_state;
  logic        grant_a, grant_b, stale;

  typedef struct {
    string       name;
    logic [15:0] bs;
    logic        ga;
    logic        gb;
    logic        st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  n64_button_arbiter #(.STALE_CYCLES(4)) dut (
    .sample_clk    (clk),
    .reset         (rst),
    .cur_operation (cur_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .valid_a       (valid_a),
    .valid_b       (valid_b),
    .data_a        (data_a),
    .data_b        (data_b),
    .button_state  (button_state),
    .grant_a       (grant_a),
    .grant_b       (grant_b),
    .stale         (stale)
  );

  // Monitor: compares the DUT outputs against the queued expectations,
  // sampling on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (button_state === e.bs && grant_a === e.ga && grant_b === e.gb && stale === e.st)
        n_pass++;
      else
        $display("FAIL %s: got bs=%h ga=%b gb=%b stale=%b, want bs=%h ga=%b gb=%b stale=%b",
                 e.name, button_state, grant_a, grant_b, stale, e.bs, e.ga, e.gb, e.st);
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic c(input logic op, input logic ra, input logic rb, input logic va,
                   input logic vb, input logic [15:0] da, input logic [15:0] db);
    cur_op  = op;
    req_a   = ra;
    req_b   = rb;
    valid_a = va;
    valid_b = vb;
    data_a  = da;
    data_b  = db;
    @(posedge clk);
    #1;
  endtask

  task automatic e(input string name, input logic [15:0] bs, input logic ga,
                   input logic gb, input logic st);
    exp_t x;
    x.name = name;
    x.bs   = bs;
    x.ga   = ga;
    x.gb   = gb;
    x.st   = st;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    c(0, 0, 0, 0, 0, 16'h0, 16'h0);
    c(0, 0, 0, 0, 0, 16'h0, 16'h0);
    e("reset", 16'h0000, 0, 0, 0);
    rst = 1'b0;
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("grant_a", 16'h0000, 1, 0, 0);
    c(0, 1, 0, 1, 0, 16'h8001, 16'h0);  e("valid_a", 16'h8001, 1, 0, 0);

    // Round-robin on ties
    rst = 1'b1;
    c(0, 1, 1, 0, 0, 16'h0, 16'h0);     e("reset2", 16'h0000, 0, 0, 0);
    rst = 1'b0;
    c(0, 1, 1, 0, 0, 16'h0, 16'h0);     e("tie_a", 16'h0000, 1, 0, 0);
    c(0, 0, 1, 0, 0, 16'h0, 16'h0);     e("drop_a", 16'h0000, 0, 0, 0);
    c(0, 0, 1, 0, 0, 16'h0, 16'h0);     e("rr_b", 16'h0000, 0, 1, 0);
    c(0, 0, 0, 0, 0, 16'h0, 16'h0);     e("drop_b", 16'h0000, 0, 0, 0);
    c(0, 1, 1, 0, 0, 16'h0, 16'h0);     e("rr_a", 16'h0000, 1, 0, 0);

    // TX deferral: data is parked during TX and the last write wins
    c(1, 1, 0, 1, 0, 16'h1111, 16'h0);  e("tx_hold1", 16'h0000, 1, 0, 0);
    c(1, 1, 0, 1, 0, 16'h2222, 16'h0);  e("tx_hold2", 16'h0000, 1, 0, 0);
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("tx_commit", 16'h2222, 1, 0, 0);
    c(1, 1, 0, 1, 0, 16'h1111, 16'h0);  e("tx_hold3", 16'h2222, 1, 0, 0);
    c(0, 1, 0, 1, 0, 16'h3333, 16'h0);  e("rx_override", 16'h3333, 1, 0, 0);
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("pending_clear", 16'h3333, 1, 0, 0);

    // A non-owner valid neither drives data nor resets the timer
    c(0, 1, 0, 0, 1, 16'h0, 16'hFFFF);  e("nonowner", 16'h3333, 1, 0, 0);
    c(0, 1, 0, 0, 1, 16'h0, 16'hFFFF);  e("nonowner2", 16'h3333, 1, 0, 0);
    c(0, 1, 0, 0, 1, 16'h0, 16'hFFFF);  e("nonowner3", 16'h3333, 1, 0, 0);
    c(0, 1, 0, 0, 1, 16'h0, 16'hFFFF);  e("nonowner_timeout", 16'h0000, 0, 0, 1);
    c(0, 0, 0, 0, 0, 16'h0, 16'h0);     e("stale_sticky", 16'h0000, 0, 0, 1);
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("regrant_a", 16'h0000, 1, 0, 0);
    c(0, 0, 0, 0, 0, 16'h0, 16'h0);     e("idle2", 16'h0000, 0, 0, 0);

    // Timeout reached during TX waits for the next RX cycle
    c(0, 0, 1, 0, 0, 16'h0, 16'h0);     e("grant_b2", 16'h0000, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      c(1, 0, 1, 0, 0, 16'h0, 16'h0);   e("tx_no_release", 16'h0000, 0, 1, 0);
    end
    c(0, 0, 1, 0, 0, 16'h0, 16'h0);     e("timeout_b", 16'h0000, 0, 0, 1);
    c(0, 0, 1, 0, 0, 16'h0, 16'h0);     e("regrant_b", 16'h0000, 0, 1, 0);

    // Simultaneous events
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("drop_b2", 16'h0000, 0, 0, 0);
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("grant_a3", 16'h0000, 1, 0, 0);
    c(0, 0, 0, 1, 0, 16'h00FF, 16'h0);  e("drop_with_valid", 16'h0000, 0, 0, 0);
    c(0, 1, 0, 1, 0, 16'h1234, 16'h0);  e("grant_valid_ignored", 16'h0000, 1, 0, 0);
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("no_late_data", 16'h0000, 1, 0, 0);
    c(1, 1, 0, 1, 0, 16'hABCD, 16'h0);  e("tx_pend", 16'h0000, 1, 0, 0);
    rst = 1'b1;
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("reset_pending", 16'h0000, 0, 0, 0);
    rst = 1'b0;
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("post_reset_grant", 16'h0000, 1, 0, 0);
    c(0, 1, 0, 0, 0, 16'h0, 16'h0);     e("no_pending_leak", 16'h0000, 1, 0, 0);

    // A request change during TX is acted on at the next RX cycle
    c(1, 0, 0, 0, 0, 16'h0, 16'h0);     e("req_drop_tx", 16'h0000, 1, 0, 0);
    c(0, 0, 0, 0, 0, 16'h0, 16'h0);     e("req_drop_rx", 16'h0000, 0, 0, 0);
    c(1, 0, 1, 0, 0, 16'h0, 16'h0);     e("req_tx_wait", 16'h0000, 0, 0, 0);
    c(0, 0, 1, 0, 0, 16'h0, 16'h0);     e("req_tx_grant", 16'h0000, 0, 1, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/n64_button_arbiter.md
# n64_button_arbiter

Shares the 16-bit `button_state` input of the N64 controller emulator between two button sources: source A (physical pad scanner) and source B (replay/debug injector). Grants ownership to one source at a time with round-robin fairness. Commits new button data and ownership changes only while the emulator is in RX, so a TX response frame never carries torn data. Releases a silent owner after a timeout and forces neutral buttons.

## Interface
- `STALE_CYCLES`, default 1000000: number of `sample_clk` cycles without an owner `valid` before forced release. Minimum 2.
- `sample_clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cur_operation`  in  1  emulator phase: 0 = RX (commit window), 1 = TX (freeze).
- `req_a`, `req_b`  in  1  level ownership requests.
- `valid_a`, `valid_b`  in  1  single-cycle data strobes.
- `data_a`, `data_b`  in  16  button words, sampled when the matching `valid` is high.
- `button_state`  out  16  registered; drives the emulator's `button_state`.
- `grant_a`, `grant_b`  out  1  registered, one-hot or zero; high while that source owns.
- `stale`  out  1  registered; sticky flag meaning the last release was caused by timeout.

## Operation
- **States:** IDLE, OWN_A, OWN_B. Encoded in registers, plus `last_grant` (1 bit), `timer`, `pending` (1 bit) and `pending_data` (16 bits).
- **Reset values:** state IDLE, `button_state`=16'h0000, grants 0, `stale` 0, `timer` 0, `pending` 0, `last_grant`=B (so A wins the first tie).
- **Commit cycle:** any cycle with `cur_operation`=0. State transitions and `button_state` writes occur only in commit cycles. In TX cycles, state and `button_state` hold; only `timer` and the pending capture run.
- **IDLE, commit cycle:**
  - Only one `req` high: grant that source.
  - Both high: grant the source that is not `last_grant`.
  - On grant: `last_grant` ← granted source, `timer` ← 0, `stale` ← 0, `pending` ← 0.
  - `button_state` stays 0 in IDLE.
- **OWN_x, commit cycle, in priority order:**
  1. `req_x`=0 → IDLE, `button_state` ← 0, `stale` unchanged.
  2. `timer`==`STALE_CYCLES` → IDLE, `button_state` ← 0, `stale` ← 1.
  3. `valid_x`=1 → `button_state` ← `data_x`, `pending` ← 0.
  4. `pending`=1 → `button_state` ← `pending_data`, `pending` ← 0.
- **OWN_x, TX cycle:** if `valid_x`=1, then `pending_data` ← `data_x` and `pending` ← 1. Last write wins.
- **Timer:**
  - Cleared on grant and on every owner `valid`, in both phases.
  - Otherwise increments in OWN states and saturates at `STALE_CYCLES`.
  - Width is $clog2(`STALE_CYCLES`+1).
  - Held at 0 in IDLE.
- **Ignored inputs:** `valid` from the non-owner is ignored entirely. A `valid` in the same cycle as the grant decision is also ignored, because the grant is not yet visible.
- **`req` during TX:** a request that drops during TX is acted on at the first RX cycle, if it is still low then.
- **Reset:** `reset` mid-ownership or mid-pending returns all registers to their reset values on the next edge.

## Timing
- Every output is registered. `grant_*` and `button_state` change 1 cycle after the deciding commit-cycle edge.
- Owner `valid` in RX → `button_state` updates on the next edge (latency 1).
- Owner `valid` in TX → `button_state` updates 1 cycle after the first RX cycle.
- Grant latency from `req` rising in RX: 1 cycle. If `req` rises during TX: 1 cycle after TX ends.
- A timeout asserts at the first commit cycle with `timer`==`STALE_CYCLES`, so release can be delayed by a long TX phase.
- `stale` stays set until the next grant.

## Test plan
- **Reset:** hold `reset` 2 cycles → all outputs 0. Then `req_a`=1 with RX → `grant_a`=1 after 1 cycle. Then `valid_a` with `data_a`=16'h8001 → `button_state`=16'h8001 next cycle.
- **Tie round-robin:** `req_a`=`req_b`=1 from reset → A granted. Drop `req_a` → IDLE with `button_state`=0. Next cycle → B granted. Drop `req_b`, raise both again → A granted.
- **TX deferral:** owner A, `cur_operation`=1, `valid_a` twice with 16'h1111 then 16'h2222 → `button_state` unchanged during TX. After RX returns → 16'h2222 one cycle later. A fresh `valid_a` with 16'h3333 in that first RX cycle → 16'h3333 wins.
- **Timeout:** `STALE_CYCLES`=4, owner B, no `valid_b` → after 4 counted cycles, with RX: `grant_b`=0, `button_state`=0, `stale`=1. Re-grant → `stale`=0.
- **Non-owner ignored:** owner A, `valid_b` with 16'hFFFF → `button_state` unchanged, `timer` not cleared.
- **Simultaneous events:** owner A, `req_a` drops in the same RX cycle as `valid_a` with 16'h00FF → IDLE, `button_state`=0. Also assert `reset` while `pending`=1 → pending data never appears on `button_state`.
